// File: rtl/data_mem_be_pkg.sv
// Shared types and helpers for the byte-enabled data memory and its lane aligner.
// The ML coprocessor uses the same request encoding, so these types are common to both.
package data_mem_pkg;

  typedef enum logic [1:0] {
    SZ_B    = 2'b00,
    SZ_H    = 2'b01,
    SZ_W    = 2'b10,
    SZ_RSVD = 2'b11
  } mem_size_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_RANGE    = 2'b10,
    ERR_REQ      = 2'b11
  } mem_err_e;

  // Byte enables for a store of the given size at the given byte lane.
  function automatic logic [3:0] byte_en(input mem_size_e size, input logic [1:0] lane);
    logic [3:0] be;
    case (size)
      SZ_B:    be = 4'b0001 << lane;
      SZ_H:    be = lane[1] ? 4'b1100 : 4'b0011;
      SZ_W:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/data_mem_be_mem_align.sv
// Combinational lane aligner: store-data replication with byte enables, and
// load lane select with sign/zero extension. Shared with the coprocessor scratchpad.
module mem_align
  import data_mem_pkg::*;
(
  input  mem_size_e   size_i,
  input  logic [1:0]  lane_i,
  input  logic        unsigned_i,
  input  logic [31:0] st_data_i,
  output logic [31:0] st_data_o,
  output logic [3:0]  st_be_o,
  input  logic [31:0] ld_word_i,
  output logic [31:0] ld_data_o
);

  logic [31:0] ld_shifted;

  always_comb begin
    st_be_o = byte_en(size_i, lane_i);
    case (size_i)
      SZ_B:    st_data_o = {4{st_data_i[7:0]}};
      SZ_H:    st_data_o = {2{st_data_i[15:0]}};
      default: st_data_o = st_data_i;
    endcase
  end

  always_comb begin
    ld_shifted = ld_word_i >> {lane_i, 3'b000};
    case (size_i)
      SZ_B:    ld_data_o = unsigned_i ? {24'h0, ld_shifted[7:0]}
                                      : {{24{ld_shifted[7]}}, ld_shifted[7:0]};
      SZ_H:    ld_data_o = unsigned_i ? {16'h0, ld_shifted[15:0]}
                                      : {{16{ld_shifted[15]}}, ld_shifted[15:0]};
      default: ld_data_o = ld_word_i;
    endcase
  end

endmodule

// File: rtl/data_mem_be.sv
// Byte/half/word data memory for the MEM stage: per-byte write enables, registered
// extended load data with a valid strobe, and registered error reporting.
module data_mem_be
  import data_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter bit          INIT_ZERO   = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        read_valid,
  output logic        err,
  output logic [1:0]  err_code
);

  localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN_BYTES = 32'(DEPTH_WORDS * 4);
  localparam logic [31:0] INIT_WORD  = INIT_ZERO ? 32'h0 : 'x;

  mem_size_e        size_e;
  logic [31:0]      offset;
  logic             in_range;
  logic             misaligned;
  logic             req;
  mem_err_e         req_err;
  logic             rd_ok;
  logic             wr_ok;
  logic [IDX_W-1:0] word_idx;

  logic [31:0] st_data;
  logic [3:0]  st_be;
  logic [31:0] ld_word;
  logic [31:0] ld_data;

  logic [31:0] read_data_q, read_data_d;
  logic        read_valid_q, read_valid_d;
  logic        err_q, err_d;
  mem_err_e    err_code_q, err_code_d;

  logic [3:0][7:0] mem [DEPTH_WORDS] = '{default: INIT_WORD};

  assign size_e = mem_size_e'(size);

  // An address below BASE_ADDR wraps to a large offset, so one compare covers both bounds.
  always_comb begin
    offset     = addr - BASE_ADDR;
    in_range   = offset < SPAN_BYTES;
    word_idx   = offset[IDX_W+1:2];
    misaligned = ((size_e == SZ_H) && addr[0]) ||
                 ((size_e == SZ_W) && (addr[1:0] != 2'b00));
    req        = mem_read || mem_write;
    req_err    = ERR_NONE;
    if (req) begin
      if ((mem_read && mem_write) || (size_e == SZ_RSVD)) req_err = ERR_REQ;
      else if (!in_range)                                 req_err = ERR_RANGE;
      else if (misaligned)                                req_err = ERR_MISALIGN;
    end
    rd_ok = mem_read  && (req_err == ERR_NONE);
    wr_ok = mem_write && (req_err == ERR_NONE);
  end

  mem_align u_align (
    .size_i     (size_e),
    .lane_i     (addr[1:0]),
    .unsigned_i (unsigned_ld),
    .st_data_i  (write_data),
    .st_data_o  (st_data),
    .st_be_o    (st_be),
    .ld_word_i  (ld_word),
    .ld_data_o  (ld_data)
  );

  assign ld_word = mem[word_idx];

  // NOTE: the array has no reset branch; resetting it would prevent block-RAM inference.
  always_ff @(posedge clk) begin
    if (rst_n && wr_ok) begin
      for (int b = 0; b < 4; b++) begin
        if (st_be[b]) mem[word_idx][b] <= st_data[8*b +: 8];
      end
    end
  end

  always_comb begin
    read_data_d  = rd_ok ? ld_data : read_data_q;
    read_valid_d = rd_ok;
    err_d        = (req_err != ERR_NONE);
    err_code_d   = req_err;
  end

  // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      read_data_q  <= 32'h0;
      read_valid_q <= 1'b0;
      err_q        <= 1'b0;
      err_code_q   <= ERR_NONE;
    end else begin
      read_data_q  <= read_data_d;
      read_valid_q <= read_valid_d;
      err_q        <= err_d;
      err_code_q   <= err_code_d;
    end
  end

  assign read_data  = read_data_q;
  assign read_valid = read_valid_q;
  assign err        = err_q;
  assign err_code   = err_code_q;

endmodule

// File: tb/tb_data_mem_be.sv
// Scoreboard bench for data_mem_be: a default instance and a small instance at 0x1000.
// Each request pushes its expected next-cycle outcome; it is popped after the edge.
module tb_data_mem_be;

  logic clk = 1'b0;
  logic rst_n;

  logic        a_rd, a_wr, a_uns, b_rd, b_wr, b_uns;
  logic [1:0]  a_sz, b_sz;
  logic [31:0] a_addr, a_wd, b_addr, b_wd;
  logic [31:0] a_rdata, b_rdata;
  logic        a_vld, a_err, b_vld, b_err;
  logic [1:0]  a_code, b_code;

  typedef struct {
    bit          sel;
    bit          vld;
    bit          err;
    logic [1:0]  code;
    logic [31:0] data;
    string       tag;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] last_rd [2];
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  data_mem_be dut_a (
    .clk(clk), .rst_n(rst_n), .mem_read(a_rd), .mem_write(a_wr), .size(a_sz),
    .unsigned_ld(a_uns), .addr(a_addr), .write_data(a_wd), .read_data(a_rdata),
    .read_valid(a_vld), .err(a_err), .err_code(a_code)
  );

  data_mem_be #(.DEPTH_WORDS(4), .BASE_ADDR(32'h0000_1000), .INIT_ZERO(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .mem_read(b_rd), .mem_write(b_wr), .size(b_sz),
    .unsigned_ld(b_uns), .addr(b_addr), .write_data(b_wd), .read_data(b_rdata),
    .read_valid(b_vld), .err(b_err), .err_code(b_code)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic rd, input logic wr, input logic [1:0] sz,
                       input logic uns, input logic [31:0] a, input logic [31:0] wd);
    {a_rd, a_wr, a_sz, a_uns, a_addr, a_wd} = '0;
    {b_rd, b_wr, b_sz, b_uns, b_addr, b_wd} = '0;
    if (!sel) {a_rd, a_wr, a_sz, a_uns, a_addr, a_wd} = {rd, wr, sz, uns, a, wd};
    else      {b_rd, b_wr, b_sz, b_uns, b_addr, b_wd} = {rd, wr, sz, uns, a, wd};
  endtask

  // Advance one edge and compare the DUT output against the oldest expectation.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    if (!e.sel) begin
      check({e.tag, ".valid"}, {31'h0, a_vld}, {31'h0, e.vld});
      check({e.tag, ".err"},   {31'h0, a_err}, {31'h0, e.err});
      check({e.tag, ".code"},  {30'h0, a_code}, {30'h0, e.code});
      check({e.tag, ".data"},  a_rdata, e.data);
    end else begin
      check({e.tag, ".valid"}, {31'h0, b_vld}, {31'h0, e.vld});
      check({e.tag, ".err"},   {31'h0, b_err}, {31'h0, e.err});
      check({e.tag, ".code"},  {30'h0, b_code}, {30'h0, e.code});
      check({e.tag, ".data"},  b_rdata, e.data);
    end
  endtask

  // One request cycle; code is the expected error code (0 = accepted).
  task automatic req(input bit sel, input logic rd, input logic wr, input logic [1:0] sz,
                     input logic uns, input logic [31:0] a, input logic [31:0] wd,
                     input logic [1:0] code, input logic [31:0] ld_exp, input string tag);
    exp_t e;
    drive(sel, rd, wr, sz, uns, a, wd);
    e.sel  = sel;
    e.err  = (code != 2'b00);
    e.code = code;
    e.vld  = rd && (code == 2'b00);
    e.data = e.vld ? ld_exp : last_rd[sel];
    e.tag  = tag;
    last_rd[sel] = e.data;
    sb_q.push_back(e);
    step();
  endtask

  task automatic st(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd,
                    input string tag);
    req(1'b0, 1'b0, 1'b1, sz, 1'b0, a, wd, 2'b00, 32'h0, tag);
  endtask

  task automatic ld(input logic [1:0] sz, input logic uns, input logic [31:0] a,
                    input logic [31:0] exp, input string tag);
    req(1'b0, 1'b1, 1'b0, sz, uns, a, 32'h0, 2'b00, exp, tag);
  endtask

  initial begin
    exp_t e;
    rst_n = 1'b0;
    last_rd[0] = 32'h0;
    last_rd[1] = 32'h0;
    drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("rst.a_data", a_rdata, 32'h0);
    check("rst.a_vld_err_code", {29'h0, a_vld, a_err, 1'b0} | {30'h0, a_code}, 32'h0);
    check("rst.b_data", b_rdata, 32'h0);
    check("rst.b_vld_err_code", {29'h0, b_vld, b_err, 1'b0} | {30'h0, b_code}, 32'h0);
    rst_n = 1'b1;

    // Word stores and loads, plus an untouched word reading as zero
    st(2'b10, 32'h0,  32'hDEADBEEF, "sw0");
    st(2'b10, 32'h4,  32'hCAFEBABE, "sw4");
    st(2'b10, 32'h10, 32'hFEEDFACE, "sw10");
    ld(2'b10, 1'b0, 32'h0,  32'hDEADBEEF, "lw0");
    ld(2'b10, 1'b0, 32'h4,  32'hCAFEBABE, "lw4");
    ld(2'b10, 1'b0, 32'h10, 32'hFEEDFACE, "lw10");
    ld(2'b10, 1'b0, 32'h1C, 32'h00000000, "lw1c");
    req(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 2'b00, 32'h0, "idle_hold");

    // Byte store followed immediately by loads of every size
    st(2'b00, 32'h2, 32'h00000080, "sb2");
    ld(2'b10, 1'b0, 32'h0, 32'hDE80BEEF, "lw0_after_sb");
    ld(2'b00, 1'b0, 32'h2, 32'hFFFFFF80, "lb2");
    ld(2'b00, 1'b1, 32'h2, 32'h00000080, "lbu2");
    ld(2'b01, 1'b0, 32'h2, 32'hFFFFDE80, "lh2");
    ld(2'b01, 1'b1, 32'h0, 32'h0000BEEF, "lhu0");
    ld(2'b00, 1'b0, 32'h3, 32'hFFFFFFDE, "lb3");
    ld(2'b10, 1'b1, 32'h10, 32'hFEEDFACE, "lw_uns_ignored");

    // Halfword store, misaligned requests leave memory alone
    st(2'b01, 32'h6, 32'h1234ABCD, "sh6");
    ld(2'b10, 1'b0, 32'h4, 32'hABCDBABE, "lw4_after_sh");
    req(1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h5, 32'h11223344, 2'b01, 32'h0, "sw5_misalign");
    ld(2'b10, 1'b0, 32'h4, 32'hABCDBABE, "lw4_unchanged");
    req(1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 32'h3, 32'h0, 2'b01, 32'h0, "lh3_misalign");
    req(1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h2, 32'h0, 2'b01, 32'h0, "lw2_misalign");

    // Range and priority on the default instance
    req(1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h1000, 32'h0, 2'b10, 32'h0, "lw_top_range");
    req(1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h1002, 32'h0, 2'b10, 32'h0, "range_over_misalign");
    req(1'b0, 1'b1, 1'b0, 2'b11, 1'b0, 32'h1000, 32'h0, 2'b11, 32'h0, "rsvd_over_range");

    // Small instance with a non-zero base
    req(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0FFC, 32'h0, 2'b10, 32'h0, "b_below_base");
    req(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h1010, 32'h0, 2'b10, 32'h0, "b_above_top");
    req(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h100C, 32'h0, 2'b00, 32'h0, "b_lw_last");
    req(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h100C, 32'h5A5A1234, 2'b00, 32'h0, "b_sw_last");
    req(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h100C, 32'h0, 2'b00, 32'h5A5A1234, "b_lw_back");
    req(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h1000, 32'h0, 2'b00, 32'h0, "b_lw_first");

    // Conflicting and reserved-size requests
    req(1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 32'h0, 32'h0, 2'b11, 32'h0, "rd_wr_conflict");
    ld(2'b10, 1'b0, 32'h0, 32'hDE80BEEF, "lw0_after_conflict");
    req(1'b0, 1'b1, 1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 2'b11, 32'h0, "rsvd_read");

    // Back-to-back loads
    ld(2'b10, 1'b0, 32'h0,  32'hDE80BEEF, "b2b0");
    ld(2'b10, 1'b0, 32'h4,  32'hABCDBABE, "b2b1");
    ld(2'b10, 1'b0, 32'h10, 32'hFEEDFACE, "b2b2");

    // Reset with a store pending: store dropped, outputs cleared
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h0, 32'h11111111);
    e.sel = 1'b0; e.vld = 1'b0; e.err = 1'b0; e.code = 2'b00; e.data = 32'h0;
    e.tag = "rst_with_sw";
    sb_q.push_back(e);
    last_rd[0] = 32'h0;
    last_rd[1] = 32'h0;
    step();
    rst_n = 1'b1;
    ld(2'b10, 1'b0, 32'h0, 32'hDE80BEEF, "lw0_after_rst");
    ld(2'b10, 1'b0, 32'h4, 32'hABCDBABE, "lw4_after_rst");

    drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    check("sb_empty", 32'(sb_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
